// File: rtl/mul_share_pkg.sv
// Shared types and constants for the multiplier-sharing controller.
// Signed operation is enabled by defining MUL_SHARE_SIGNED_EN.
package mul_share_pkg;
  localparam int MUL_W  = 32;
  localparam int PROD_W = 64;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  function automatic bit params_ok(int num_req, int mul_cycles, int id_w);
    return (num_req >= 2) && (num_req <= 8) && (mul_cycles >= 1) &&
           (mul_cycles <= 15) && (id_w >= $clog2(num_req));
  endfunction
endpackage

// File: rtl/mul_rr_arbiter.sv
// Round-robin grant: first asserted request at or above ptr_i, wrapping.
module mul_rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = 1
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0]   idx_o,
  output logic               any_o
);
  always_comb begin
    int j;
    j     = 0;
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = (int'(ptr_i) + k) % NUM_REQ;
      if (!any_o && req_i[j]) begin
        any_o    = 1'b1;
        gnt_o[j] = 1'b1;
        idx_o    = IDX_W'(j);
      end
    end
  end
endmodule

// File: rtl/multiplier_32bit.sv
// Combinational unsigned 32x32 -> 64 multiplier shared by the controller.
module multiplier_32bit (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [63:0] product
);
  assign product = 64'(a) * 64'(b);
endmodule

// File: rtl/mul_share_ctrl.sv
// Shares one multiplier_32bit among NUM_REQ round-robin requesters, one op in flight.
// Optional MUL_SHARE_SIGNED_EN adds per-requester two's-complement operation.
module mul_share_ctrl
  import mul_share_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int MUL_CYCLES = 1,
  parameter int ID_W       = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*MUL_W-1:0] req_a,
  input  logic [NUM_REQ*MUL_W-1:0] req_b,
`ifdef MUL_SHARE_SIGNED_EN
  input  logic [NUM_REQ-1:0]       req_signed,
`endif
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [ID_W-1:0]          rsp_id,
  output logic [PROD_W-1:0]        rsp_product,
  output logic                     busy
);
  if (!params_ok(NUM_REQ, MUL_CYCLES, ID_W)) begin : g_bad_params
    $error("mul_share_ctrl: parameter out of range");
  end

  state_t              state_q;
  logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d, rsp_id_q, gnt_idx;
  logic [MUL_W-1:0]    op_a_q, op_b_q, sel_a, sel_b, mag_a, mag_b;
  logic [CNT_W-1:0]    cnt_q;
  logic [PROD_W-1:0]   rsp_product_q, prod, prod_d;
  logic                rsp_valid_q, gnt_any, sgn_q, sgn_sel;
  logic [NUM_REQ-1:0]  gnt;

  mul_rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(ID_W)) u_arb (
    .req_i (req_valid),
    .ptr_i (rr_ptr_q),
    .gnt_o (gnt),
    .idx_o (gnt_idx),
    .any_o (gnt_any)
  );

  assign req_ready = (state_q == IDLE) ? gnt : '0;
  assign busy      = (state_q != IDLE);
  assign sel_a     = req_a[gnt_idx*MUL_W +: MUL_W];
  assign sel_b     = req_b[gnt_idx*MUL_W +: MUL_W];
  assign rr_ptr_d  = (gnt_idx == ID_W'(NUM_REQ-1)) ? '0 : gnt_idx + 1'b1;

`ifdef MUL_SHARE_SIGNED_EN
  // Multiply magnitudes; the sign is reapplied to the full 64-bit product.
  assign sgn_sel = req_signed[gnt_idx];
  assign mag_a   = (sgn_q && op_a_q[MUL_W-1]) ? -op_a_q : op_a_q;
  assign mag_b   = (sgn_q && op_b_q[MUL_W-1]) ? -op_b_q : op_b_q;
  assign prod_d  = (sgn_q && (op_a_q[MUL_W-1] ^ op_b_q[MUL_W-1])) ? -prod : prod;
`else
  assign sgn_sel = 1'b0;
  assign mag_a   = op_a_q;
  assign mag_b   = op_b_q;
  assign prod_d  = prod;
`endif

  multiplier_32bit u_mul (.a(mag_a), .b(mag_b), .product(prod));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      rr_ptr_q      <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_id_q      <= '0;
      rsp_product_q <= '0;
      op_a_q        <= '0;
      op_b_q        <= '0;
      sgn_q         <= 1'b0;
      cnt_q         <= '0;
    end else begin
      case (state_q)
        IDLE: if (gnt_any) begin
          op_a_q   <= sel_a;
          op_b_q   <= sel_b;
          sgn_q    <= sgn_sel;
          rsp_id_q <= gnt_idx;
          rr_ptr_q <= rr_ptr_d;
          cnt_q    <= CNT_W'(MUL_CYCLES - 1);
          state_q  <= CALC;
        end
        CALC: if (cnt_q != '0) begin
          cnt_q <= cnt_q - 1'b1;
        end else begin
          rsp_product_q <= prod_d;
          rsp_valid_q   <= 1'b1;
          state_q       <= DONE;
        end
        DONE: if (rsp_ready) begin
          rsp_valid_q <= 1'b0;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rsp_valid   = rsp_valid_q;
  assign rsp_id      = rsp_id_q;
  assign rsp_product = rsp_product_q;
endmodule

// File: tb/tb_mul_share_ctrl.sv
// Scoreboard bench for mul_share_ctrl: drivers push expected responses, a monitor pops and compares.
module tb_mul_share_ctrl;
  localparam int NUM_REQ = 2, MUL_CYCLES = 1, ID_W = 1;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NUM_REQ-1:0]    req_valid, req_ready;
  logic [NUM_REQ*32-1:0] req_a, req_b;
  logic                  rsp_valid, rsp_ready, busy;
  logic [ID_W-1:0]       rsp_id;
  logic [63:0]           rsp_product;
`ifdef MUL_SHARE_SIGNED_EN
  logic [NUM_REQ-1:0]    req_signed;
`endif

  always #5 clk = ~clk;

  mul_share_ctrl #(.NUM_REQ(NUM_REQ), .MUL_CYCLES(MUL_CYCLES), .ID_W(ID_W)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
`ifdef MUL_SHARE_SIGNED_EN
    .req_signed(req_signed),
`endif
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_product(rsp_product), .busy(busy)
  );

  typedef struct packed { logic [ID_W-1:0] id; logic [63:0] prod; } exp_t;
  exp_t exp_q[$];
  int   n_chk = 0, n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input int id, input logic [63:0] p);
    exp_t e;
    e.id   = ID_W'(id);
    e.prod = p;
    exp_q.push_back(e);
  endtask

  // Monitor: pops on each response handshake, checks hold stability while stalled.
  logic            hold_prev = 1'b0;
  logic [ID_W-1:0] id_prev;
  logic [63:0]     prod_prev;
  always @(negedge clk) begin
    if (!rst) begin
      if (hold_prev) begin
        check("hold_valid", rsp_valid, 1);
        check("hold_id", rsp_id, id_prev);
        check("hold_product", rsp_product, prod_prev);
      end
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) check("unexpected_rsp", 1, 0);
        else begin
          exp_t e;
          e = exp_q.pop_front();
          check("rsp_id", rsp_id, e.id);
          check("rsp_product", rsp_product, e.prod);
        end
      end
      hold_prev = rsp_valid && !rsp_ready;
      id_prev   = rsp_id;
      prod_prev = rsp_product;
    end else hold_prev = 1'b0;
  end

  // Drive one request and hold it until accepted (bounded).
  task automatic issue(input int i, input logic [31:0] a, input logic [31:0] b);
    bit done;
    done = 0;
    req_valid[i]      = 1'b1;
    req_a[32*i +: 32] = a;
    req_b[32*i +: 32] = b;
    for (int c = 0; c < 50 && !done; c++) begin
      @(negedge clk);
      if (req_ready[i]) begin
        done = 1;
        @(posedge clk); #1;
      end
    end
    req_valid[i] = 1'b0;
    if (!done) check("grant_timeout", 0, 1);
  endtask

  task automatic wait_drain();
    for (int c = 0; c < 50 && exp_q.size() != 0; c++) @(negedge clk);
    check("queue_drained", 64'(exp_q.size()), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [31:0] a0 [2], b0 [2], a1 [2], b1 [2];
    logic [NUM_REQ-1:0] r;
    int k0, k1;
    bit seen;
    rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 1'b1;
`ifdef MUL_SHARE_SIGNED_EN
    req_signed = '0;
`endif
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_rsp_valid", rsp_valid, 0);
    check("reset_busy", busy, 0);
    check("reset_req_ready", req_ready, 0);
    check("reset_rsp_id", rsp_id, 0);
    check("reset_rsp_product", rsp_product, 0);
    @(posedge clk); #1;

    // Reset while in CALC: the request is dropped, no response.
    issue(0, 32'd5, 32'd7);
    check("midcalc_busy", busy, 1);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("midcalc_rsp_valid", rsp_valid, 0);
    check("midcalc_busy_after", busy, 0);
    repeat (4) @(negedge clk);
    check("midcalc_no_rsp", rsp_valid, 0);
    @(posedge clk); #1;

    // Basic 2*3 on requester 0, with latency check.
    push(0, 64'd6);
    issue(0, 32'd2, 32'd3);
    check("lat_calc_valid", rsp_valid, 0);
    @(posedge clk); #1;
    check("lat_done_valid", rsp_valid, 1);
    wait_drain();

    // Requester 1 edge operands.
    push(1, 64'hFFFFFFFE00000001);
    issue(1, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_drain();
    push(1, 64'd0);
    issue(1, 32'd0, 32'h12345678);
    wait_drain();

    // Both continuously valid: pointer is at 0 so grants go 0,1,0,1.
    a0 = '{32'd7, 32'hDEADBEEF}; b0 = '{32'd9, 32'd1};
    a1 = '{32'h10000, 32'd100};  b1 = '{32'h10000, 32'd1000};
    push(0, 64'd63); push(1, 64'h100000000); push(0, 64'hDEADBEEF); push(1, 64'd100000);
    k0 = 0; k1 = 0;
    for (int c = 0; c < 100 && (k0 < 2 || k1 < 2); c++) begin
      req_valid[0] = (k0 < 2); req_valid[1] = (k1 < 2);
      req_a[31:0]  = a0[k0 < 2 ? k0 : 1]; req_b[31:0]  = b0[k0 < 2 ? k0 : 1];
      req_a[63:32] = a1[k1 < 2 ? k1 : 1]; req_b[63:32] = b1[k1 < 2 ? k1 : 1];
      @(negedge clk);
      r = req_ready;
      check("ready_onehot", 64'($onehot0(r)), 1);
      @(posedge clk); #1;
      if (r[0]) k0++;
      if (r[1]) k1++;
    end
    req_valid = '0;
    check("both_grants", 64'(k0 + k1), 4);
    wait_drain();

    // Stall in DONE for 5 cycles; a new request must wait.
    rsp_ready = 1'b0;
    push(0, 64'd200);
    issue(0, 32'd10, 32'd20);
    seen = 0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      seen = rsp_valid;
    end
    check("stall_rsp_seen", seen, 1);
    @(posedge clk); #1;
    req_valid[1] = 1'b1; req_a[63:32] = 32'd3; req_b[63:32] = 32'd4;
    repeat (5) begin
      @(negedge clk);
      check("stall_no_ready", req_ready, 0);
      check("stall_busy", busy, 1);
    end
    push(1, 64'd12);
    rsp_ready = 1'b1;
    issue(1, 32'd3, 32'd4);
    wait_drain();

    // Unsigned 0xFFFFFFFF*2.
    push(0, 64'h1FFFFFFFE);
    issue(0, 32'hFFFFFFFF, 32'd2);
    wait_drain();
`ifdef MUL_SHARE_SIGNED_EN
    req_signed = '1;
    push(0, 64'hFFFFFFFFFFFFFFFE);
    issue(0, 32'hFFFFFFFF, 32'd2);
    wait_drain();
    push(1, 64'd1);
    issue(1, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_drain();
    push(0, 64'hFFFFFFFF80000000);
    issue(0, 32'h80000000, 32'd1);
    wait_drain();
    req_signed = '0;
`endif

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
